spi_controller: RTL and testbench

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_controller.sv | 133 +++++++++++++
 tb/tb_spi_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_controller : mode-0 SPI write-only master, 16-bit {data, addr, 1} frames
// Optional chip-select gap phase: define SPI_CS_GAP_EN.       Rev 1.0
// ---------------------------------------------------------------------------
module spi_controller #(
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_data,
   output logic       sclk,
   output logic       ncs,
   output logic       copi,
   output logic       busy,
   output logic       done
);

   localparam logic [7:0] C_DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [4:0] C_LAST_BIT = 5'd16;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_HIGH  = 3'd2,
      S_LOW   = 3'd3,
      S_HOLD  = 3'd4,
      S_GAP   = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_div_cnt;
   logic [4:0]  r_bit_cnt;
   logic [15:0] r_shift;
   logic        r_done;
   logic        w_div_last;
   logic        w_accept;
   logic        w_phase_chg;

`ifdef SPI_CS_GAP_EN
   localparam logic [15:0] C_GAP_LAST = 16'(CS_GAP * CLK_DIV - 1);
   logic [15:0] r_gap_cnt;
`endif

   if ((CLK_DIV < 1) || (CLK_DIV > 255) || (CS_GAP < 1)) begin : g_param_check
      $error("spi_controller: CLK_DIV=%0d CS_GAP=%0d out of range", CLK_DIV, CS_GAP);
   end

   always_comb begin
      w_state_nxt = r_state;
      w_div_last  = (r_div_cnt == C_DIV_LAST);
      // rst_n term keeps cmd_ready low while reset is held
      cmd_ready   = (r_state == S_IDLE) && rst_n;
      w_accept    = cmd_valid && cmd_ready;
      case (r_state)
         S_IDLE:  if (w_accept)   w_state_nxt = S_SETUP;
         S_SETUP: if (w_div_last) w_state_nxt = S_HIGH;
         S_HIGH: begin
            if (w_div_last) begin
               if (r_bit_cnt == C_LAST_BIT) w_state_nxt = S_HOLD;
               else                         w_state_nxt = S_LOW;
            end
         end
         S_LOW:   if (w_div_last) w_state_nxt = S_HIGH;
         S_HOLD: begin
`ifdef SPI_CS_GAP_EN
            if (w_div_last) w_state_nxt = S_GAP;
`else
            if (w_div_last) w_state_nxt = S_IDLE;
`endif
         end
         S_GAP: begin
`ifdef SPI_CS_GAP_EN
            if (r_gap_cnt == C_GAP_LAST) w_state_nxt = S_IDLE;
`else
            w_state_nxt = S_IDLE;
`endif
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_phase_chg = (w_state_nxt != r_state);

      sclk = (r_state == S_HIGH);
      ncs  = !((r_state == S_SETUP) || (r_state == S_HIGH) ||
               (r_state == S_LOW)   || (r_state == S_HOLD));
      busy = (r_state != S_IDLE);
      copi = !ncs && r_shift[15];
      done = r_done;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_div_cnt <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_done    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= (r_state == S_HOLD) && w_phase_chg;

         if (w_phase_chg || (r_state == S_IDLE)) r_div_cnt <= '0;
         else                                     r_div_cnt <= r_div_cnt + 8'd1;

         // counts sclk rising edges, i.e. entries into HIGH
         if (r_state == S_IDLE)
            r_bit_cnt <= '0;
         else if (w_phase_chg && (w_state_nxt == S_HIGH))
            r_bit_cnt <= r_bit_cnt + 5'd1;

         // no shift into HOLD so copi keeps bit 0 until ncs rises
         if (w_accept)
            r_shift <= {cmd_data, cmd_addr, 1'b1};
         else if ((r_state == S_HIGH) && (w_state_nxt == S_LOW))
            r_shift <= {r_shift[14:0], 1'b0};
      end
   end

`ifdef SPI_CS_GAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 r_gap_cnt <= '0;
      else if (r_state != S_GAP)  r_gap_cnt <= '0;
      else                        r_gap_cnt <= r_gap_cnt + 16'd1;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_controller.sv
`default_nettype none
// tb_spi_controller : randomized + directed checks of two spi_controller
// instances (CLK_DIV=4 and CLK_DIV=1) against a frame-level reference model.
module tb_spi_controller;

   localparam int DIV0 = 4;
   localparam int DIV1 = 1;
   localparam int GAP  = 4;
`ifdef SPI_CS_GAP_EN
   localparam int MIN_GAP = GAP * DIV0;
`else
   localparam int MIN_GAP = 1;
`endif

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [1:0] valid_v = 2'b00;
   logic [1:0] ready_v, sclk_v, ncs_v, copi_v, busy_v, done_v;
   logic [6:0] addr_v [2];
   logic [7:0] data_v [2];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   spi_controller #(.CLK_DIV(DIV0), .CS_GAP(GAP)) dut0 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(valid_v[0]), .cmd_ready(ready_v[0]),
      .cmd_addr(addr_v[0]), .cmd_data(data_v[0]), .sclk(sclk_v[0]), .ncs(ncs_v[0]),
      .copi(copi_v[0]), .busy(busy_v[0]), .done(done_v[0]));

   spi_controller #(.CLK_DIV(DIV1), .CS_GAP(GAP)) dut1 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(valid_v[1]), .cmd_ready(ready_v[1]),
      .cmd_addr(addr_v[1]), .cmd_data(data_v[1]), .sclk(sclk_v[1]), .ncs(ncs_v[1]),
      .copi(copi_v[1]), .busy(busy_v[1]), .done(done_v[1]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: wire order on copi is data[7..0], addr[6..0], then a 1.
   function automatic logic [15:0] ref_frame(input logic [6:0] a, input logic [7:0] d);
      logic [15:0] f;
      f = 16'd1;
      for (int i = 0; i < 7; i++) f[1 + i] = a[i];
      for (int i = 0; i < 8; i++) f[8 + i] = d[i];
      return f;
   endfunction

   // setup + 16 high + 15 low + hold, each CLK_DIV cycles
   function automatic int ref_low(input int div);
      return (1 + 16 + 15 + 1) * div;
   endfunction

   function automatic int div_of(input int k);
      return (k == 0) ? DIV0 : DIV1;
   endfunction

   // Bus monitor: rebuilds frames from the pins
   logic [15:0] fr_word [2][16];
   int          fr_bits [2][16];
   int          fr_low  [2][16];
   int          fr_gap  [2][16];
   int          fr_minp [2][16];
   int          fr_maxp [2][16];
   int          nfr   [2] = '{0, 0};
   int          ndone [2] = '{0, 0};
   int          nviol [2] = '{0, 0};
   logic        m_in   [2] = '{1'b0, 1'b0};
   logic        m_prev [2] = '{1'b0, 1'b0};
   logic [15:0] m_shift [2];
   int          m_nbits [2] = '{0, 0};
   int          m_low [2], m_hi [2], m_gap [2], m_last [2], m_minp [2], m_maxp [2];
   int          cyc = 0;

   always @(negedge clk) begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_in[k]   = 1'b0;
            m_prev[k] = 1'b0;
            m_hi[k]   = 0;
         end else begin
            if (done_v[k]) ndone[k]++;
            if (ncs_v[k] && (copi_v[k] || sclk_v[k])) nviol[k]++;
            if (!ncs_v[k]) begin
               if (!m_in[k]) begin
                  m_in[k]    = 1'b1;
                  m_shift[k] = '0;
                  m_nbits[k] = 0;
                  m_low[k]   = 0;
                  m_gap[k]   = m_hi[k];
                  m_last[k]  = -1;
                  m_minp[k]  = 1000000;
                  m_maxp[k]  = 0;
               end
               m_low[k]++;
               if (sclk_v[k] && !m_prev[k]) begin
                  m_shift[k] = {m_shift[k][14:0], copi_v[k]};
                  m_nbits[k]++;
                  if (m_last[k] >= 0) begin
                     if (cyc - m_last[k] < m_minp[k]) m_minp[k] = cyc - m_last[k];
                     if (cyc - m_last[k] > m_maxp[k]) m_maxp[k] = cyc - m_last[k];
                  end
                  m_last[k] = cyc;
               end
            end else begin
               if (m_in[k]) begin
                  if (nfr[k] < 16) begin
                     fr_word[k][nfr[k]] = m_shift[k];
                     fr_bits[k][nfr[k]] = m_nbits[k];
                     fr_low[k][nfr[k]]  = m_low[k];
                     fr_gap[k][nfr[k]]  = m_gap[k];
                     fr_minp[k][nfr[k]] = m_minp[k];
                     fr_maxp[k][nfr[k]] = m_maxp[k];
                  end
                  nfr[k]++;
                  m_hi[k] = 0;
               end
               m_in[k] = 1'b0;
               m_hi[k]++;
            end
            m_prev[k] = sclk_v[k];
         end
      end
   end

   task automatic send(input int k, input logic [6:0] a, input logic [7:0] d);
      int t = 0;
      @(negedge clk);
      while (!ready_v[k] && t < 5000) begin
         @(negedge clk);
         t++;
      end
      check("cmd_ready_wait", 32'(ready_v[k]), 32'd1);
      valid_v[k] = 1'b1;
      addr_v[k]  = a;
      data_v[k]  = d;
      @(posedge clk);
      #1;
      valid_v[k] = 1'b0;
      addr_v[k]  = 7'($urandom);
      data_v[k]  = 8'($urandom);
   endtask

   task automatic wait_frames(input int k, input int n);
      int t = 0;
      while (nfr[k] < n && t < 5000) begin
         @(negedge clk);
         t++;
      end
      check("frame_count", 32'(nfr[k]), 32'(n));
   endtask

   task automatic run_frame(input int k, input logic [6:0] a, input logic [7:0] d);
      int f0 = nfr[k];
      int d0 = ndone[k];
      send(k, a, d);
      wait_frames(k, f0 + 1);
      repeat (2) @(negedge clk);
      check("frame_word",   32'(fr_word[k][f0]), 32'(ref_frame(a, d)));
      check("frame_bits",   32'(fr_bits[k][f0]), 32'd16);
      check("ncs_low_len",  32'(fr_low[k][f0]),  32'(ref_low(div_of(k))));
      check("sclk_min_per", 32'(fr_minp[k][f0]), 32'(2 * div_of(k)));
      check("sclk_max_per", 32'(fr_maxp[k][f0]), 32'(2 * div_of(k)));
      check("done_pulses",  32'(ndone[k]),       32'(d0 + 1));
   endtask

   initial begin
      int f0, d0, t;
      for (int k = 0; k < 2; k++) begin
         addr_v[k] = '0;
         data_v[k] = '0;
      end

      #1 rst_n = 1'b0;
      #1;
      check("rst_ncs",   32'(ncs_v[0]),   32'd1);
      check("rst_sclk",  32'(sclk_v[0]),  32'd0);
      check("rst_copi",  32'(copi_v[0]),  32'd0);
      check("rst_done",  32'(done_v[0]),  32'd0);
      check("rst_busy",  32'(busy_v[0]),  32'd0);
      check("rst_ready", 32'(ready_v[0]), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 check("ready_after_rst", 32'(ready_v[0]), 32'd1);

      run_frame(0, 7'h04, 8'h80);

      // back-to-back with cmd_valid held high across both acceptances
      f0 = nfr[0];
      d0 = ndone[0];
      t  = 0;
      @(negedge clk);
      while (!ready_v[0] && t < 5000) begin @(negedge clk); t++; end
      valid_v[0] = 1'b1; addr_v[0] = 7'h00; data_v[0] = 8'hF0;
      @(posedge clk);
      #1 addr_v[0] = 7'h7F; data_v[0] = 8'hA5;
      t = 0;
      @(negedge clk);
      while (!ready_v[0] && t < 5000) begin @(negedge clk); t++; end
      check("b2b_second_ready", 32'(ready_v[0]), 32'd1);
      @(posedge clk);
      #1 valid_v[0] = 1'b0;
      wait_frames(0, f0 + 2);
      repeat (2) @(negedge clk);
      check("b2b_frame1", 32'(fr_word[0][f0]),     32'(ref_frame(7'h00, 8'hF0)));
      check("b2b_frame2", 32'(fr_word[0][f0 + 1]), 32'(ref_frame(7'h7F, 8'hA5)));
      check("b2b_gap_ok", 32'(fr_gap[0][f0 + 1] >= MIN_GAP), 32'd1);
      check("b2b_dones",  32'(ndone[0]),           32'(d0 + 2));

      // command offered mid-frame must be dropped
      f0 = nfr[0];
      d0 = ndone[0];
      send(0, 7'h04, 8'h80);
      repeat (40) @(negedge clk);
      valid_v[0] = 1'b1; addr_v[0] = 7'h04; data_v[0] = 8'h11;
      @(negedge clk);
      valid_v[0] = 1'b0;
      wait_frames(0, f0 + 1);
      repeat (300) @(negedge clk);
      check("ignored_frames", 32'(nfr[0]),         32'(f0 + 1));
      check("ignored_dones",  32'(ndone[0]),       32'(d0 + 1));
      check("ignored_word",   32'(fr_word[0][f0]), 32'(ref_frame(7'h04, 8'h80)));

      for (int i = 0; i < 8; i++)
         run_frame(int'($urandom_range(0, 1)), 7'($urandom), 8'($urandom));

      // asynchronous reset in the middle of a frame
      f0 = nfr[0];
      d0 = ndone[0];
      send(0, 7'($urandom), 8'($urandom));
      t = 0;
      while (!(m_in[0] && m_nbits[0] >= 7) && t < 5000) begin @(negedge clk); t++; end
      check("reached_7th_rise", 32'(m_nbits[0] >= 7), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_ncs",  32'(ncs_v[0]),  32'd1);
      check("abort_sclk", 32'(sclk_v[0]), 32'd0);
      check("abort_copi", 32'(copi_v[0]), 32'd0);
      check("abort_busy", 32'(busy_v[0]), 32'd0);
      repeat (20) @(negedge clk);
      check("abort_no_frame", 32'(nfr[0]),   32'(f0));
      check("abort_no_done",  32'(ndone[0]), 32'(d0));
      rst_n = 1'b1;
      run_frame(0, 7'h02, 8'h3C);

      run_frame(1, 7'h03, 8'hFF);

      check("copi_sclk_idle0", 32'(nviol[0]), 32'd0);
      check("copi_sclk_idle1", 32'(nviol[1]), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
